// File: rtl/gf22_sram64_burst_rd.sv
// Burst read engine for the 64-bit GF22 dual-port SRAM read port (CE1/A1/Q1).
// Issues one sequential read per cycle under a FIFO credit check and streams words out via valid/ready.
module gf22_sram64_burst_rd #(
  parameter int unsigned ABITS      = 14,
  parameter int unsigned DBITS      = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ABITS-1:0] cmd_addr,
  input  logic [ABITS-1:0] cmd_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q, rem_q;
  logic             infl_q, infl_last_q;
  logic [DBITS-1:0] fifo_data [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [OW-1:0]    occ;
  logic             credit_ok, accept, issue, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Slots already committed: stored beats plus the read whose data lands next cycle.
  always_comb begin
    occ       = {1'b0, count_q} + OW'(infl_q);
    credit_ok = occ < OW'(FIFO_DEPTH);
  end

  assign out_valid = (count_q != '0);
  assign out_data  = fifo_data[rd_ptr_q];
  assign out_last  = out_valid & fifo_last[rd_ptr_q];
  assign pop       = out_valid & out_ready;
  assign push      = infl_q;
  assign A1        = addr_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    CE1       = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_d = RUN;
      end
      RUN: begin
        CE1   = credit_ok;
        issue = credit_ok;
        if (credit_ok && (rem_q == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address walker and in-flight read tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (issue) begin
        addr_q <= addr_q + ABITS'(1);
        rem_q  <= rem_q - ABITS'(1);
      end
      infl_q      <= issue;
      infl_last_q <= issue && (rem_q == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Q1 is captured exactly one cycle after CE1; storage needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= Q1;
      fifo_last[wr_ptr_q] <= infl_last_q;
    end
  end

endmodule

// File: tb/tb_gf22_sram64_burst_rd.sv
// Bench for gf22_sram64_burst_rd: directed scenarios plus random bursts against a queue-based
// reference model and an SRAM model that returns garbage on Q1 except the cycle after a read.
module tb_gf22_sram64_burst_rd;

  localparam int unsigned ABITS = 14;
  localparam int unsigned DBITS = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NW    = 1 << ABITS;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ABITS-1:0] cmd_addr = '0;
  logic [ABITS-1:0] cmd_len = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DBITS-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             CE1;
  logic [ABITS-1:0] A1;
  logic [DBITS-1:0] Q1;

  gf22_sram64_burst_rd #(.ABITS(ABITS), .DBITS(DBITS), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  logic [DBITS-1:0] sram [NW];

  always @(posedge CLK) Q1 <= CE1 ? sram[A1] : {$urandom, $urandom};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic fixed_rdy = 1'b0;
  logic rand_rdy  = 1'b0;

  always @(posedge CLK) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  // Reference model: expected read addresses and expected {last,data} beats in order.
  logic [ABITS-1:0] exp_addr [$];
  logic [DBITS:0]   exp_beats [$];
  int               outstanding = 0;
  logic             prev_stall = 1'b0;
  logic [DBITS-1:0] prev_data = '0;

  always @(negedge CLK) begin
    if (RST) begin
      exp_addr.delete();
      exp_beats.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, prev_data);
      end
      if (CE1) begin
        check("credit", 64'(outstanding < int'(DEPTH)), 64'd1);
        check("ce1_expected", 64'(exp_addr.size() > 0), 64'd1);
        if (exp_addr.size() > 0) check("a1", 64'(A1), 64'(exp_addr.pop_front()));
        outstanding++;
      end
      if (out_valid && out_ready) begin
        check("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
        if (exp_beats.size() > 0) begin
          logic [DBITS:0] e;
          e = exp_beats.pop_front();
          check("out_data", out_data, e[DBITS-1:0]);
          check("out_last", 64'(out_last), 64'(e[DBITS]));
        end
        outstanding--;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (cmd_valid && cmd_ready) begin
        for (int i = 0; i <= int'(cmd_len); i++) begin
          logic [ABITS-1:0] a;
          a = cmd_addr + ABITS'(i);
          exp_addr.push_back(a);
          exp_beats.push_back({(i == int'(cmd_len)), sram[a]});
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a command and hold it until accepted; returns one tick after the accepting edge.
  task automatic send_cmd(input logic [ABITS-1:0] a, input logic [ABITS-1:0] l);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_accepted", 64'(ok), 64'd1);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      if (!busy && exp_beats.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 64'(ok), 64'd1);
    step();
  endtask

  initial begin
    int n_ce;
    for (int n = 0; n < int'(NW); n++) sram[n] = DBITS'(n);

    repeat (3) step();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ce1", 64'(CE1), 64'd0);
    check("rst_a1", 64'(A1), 64'd0);
    step();

    // Single beat latency
    fixed_rdy = 1'b1;
    step();
    send_cmd(14'h0010, 14'd0);
    @(negedge CLK);
    check("t1_ce1_k1", 64'(CE1), 64'd1);
    check("t1_valid_k1", 64'(out_valid), 64'd0);
    @(negedge CLK);
    check("t1_valid_k2", 64'(out_valid), 64'd0);
    @(negedge CLK);
    check("t1_valid_k3", 64'(out_valid), 64'd1);
    check("t1_data", out_data, 64'h10);
    check("t1_last", 64'(out_last), 64'd1);
    @(negedge CLK);
    check("t1_ready_after", 64'(cmd_ready), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);
    step();

    // 8-beat burst with a second command held during it
    send_cmd(14'h0100, 14'd7);
    cmd_valid = 1'b1;
    cmd_addr  = 14'h0200;
    cmd_len   = 14'd2;
    for (int k = 1; k <= 11; k++) begin
      @(negedge CLK);
      if (k <= 8) begin
        check("t2_ce1_on", 64'(CE1), 64'd1);
        check("t2_a1", 64'(A1), 64'(14'h0100 + 14'(k - 1)));
      end else begin
        check("t2_ce1_off", 64'(CE1), 64'd0);
      end
      if (k >= 3 && k <= 10) begin
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_last", 64'(out_last), 64'(k == 10));
      end
      check("t6_cmd_ready", 64'(cmd_ready), 64'(k == 11));
    end
    step();
    cmd_valid = 1'b0;
    wait_idle();

    // Back-pressure: credit limits reads to the FIFO depth
    fixed_rdy = 1'b0;
    repeat (2) step();
    send_cmd(14'h0000, 14'd15);
    n_ce = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (CE1) n_ce++;
    end
    check("t3_reads_stalled", 64'(n_ce), 64'd4);
    step();
    fixed_rdy = 1'b1;
    wait_idle();

    // Address wrap
    send_cmd(14'h3FFE, 14'd3);
    wait_idle();

    // Reset in the middle of a burst
    send_cmd(14'h0040, 14'd7);
    repeat (4) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_ce1", 64'(CE1), 64'd0);
    check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    step();
    send_cmd(14'h0020, 14'd1);
    wait_idle();

    // Random bursts with random back-pressure and random SRAM contents
    for (int n = 0; n < int'(NW); n++) sram[n] = {$urandom, $urandom};
    rand_rdy = 1'b1;
    for (int it = 0; it < 30; it++) begin
      logic [ABITS-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? 14'h3FF0 + 14'($urandom_range(0, 15)) : 14'($urandom);
      repeat ($urandom_range(0, 3)) step();
      send_cmd(a, 14'($urandom_range(0, 20)));
    end
    wait_idle();
    check("end_addr_queue", 64'(exp_addr.size()), 64'd0);
    check("end_beat_queue", 64'(exp_beats.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
